// File: rtl/band_seq_pkg.sv
// band_seq_pkg
//   Shared types and default sizing for the band-filter sequencer.
//   state_t     : sequencer FSM states (FILL, IDLE, RUN, DONE)
//   DEF_DEPTH   : default sample-queue depth (power of two)
//   DEF_TAPS    : default samples consumed per filter run
//   DEF_LAT     : default filter pipeline latency after the last tap
package band_seq_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_DEPTH = 1024;
  localparam int DEF_TAPS  = 1021;
  localparam int DEF_LAT   = 2;

endpackage

// File: rtl/band_seq_if.sv
// band_seq_if
//   Bundles the sample-queue and band-filter control signals of band_seq.
//   smpl_vld   : new sample pair present at the queue write port
//   wr_en      : queue write strobe
//   wr_ptr     : queue write address
//   rd_ptr     : queue read address shared by all band filters
//   sequencing : filter run enable (rising edge restarts the filters)
//   filt_vld   : one-cycle pulse, filter outputs valid
//   filled     : queue holds at least TAPS samples
//   overrun    : sticky, a sample arrived during a run
//   Modports: master = sample source / observer, slave = band_seq.
interface band_seq_if
  import band_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) ();

  localparam int ADDR_W = $clog2(DEPTH);

  logic              smpl_vld;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              sequencing;
  logic              filt_vld;
  logic              filled;
  logic              overrun;

  modport master (
    output smpl_vld,
    input  wr_en, wr_ptr, rd_ptr, sequencing, filt_vld, filled, overrun
  );

  modport slave (
    input  smpl_vld,
    output wr_en, wr_ptr, rd_ptr, sequencing, filt_vld, filled, overrun
  );

endinterface

// File: rtl/band_seq_mod_ptr.sv
// mod_ptr
//   Modulo-DEPTH address pointer. DEPTH is a power of two, so the natural
//   wrap of an AW-bit adder gives the modulo. Priority: clr > load > inc.
//   clk      : clock, rising edge
//   clr      : synchronous clear to 0
//   load     : load load_val
//   load_val : value to load
//   inc      : advance by one (modulo DEPTH)
//   ptr      : current pointer value
module mod_ptr #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_reg <= '0;
    end else if (load) begin
      ptr_reg <= load_val;
    end else if (inc) begin
      ptr_reg <= ptr_reg + 1'b1;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/band_seq.sv
// band_seq
//   Sequences the sample queue feeding a bank of band filters. Samples are
//   written at wr_ptr on every smpl_vld. Once TAPS samples are queued, each
//   new sample launches a run: rd_ptr sweeps the newest TAPS samples
//   (oldest first), sequencing stays high for TAPS+LAT cycles to cover the
//   filter pipeline, then filt_vld pulses for one cycle.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : band_seq_if.slave (sample strobe in, queue/filter control out)
module band_seq
  import band_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAPS  = DEF_TAPS,
  parameter int LAT   = DEF_LAT
) (
  input logic        clk,
  input logic        rst,
  band_seq_if.slave  bus
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int RUN_LEN = TAPS + LAT;
  localparam int CNT_W   = $clog2(RUN_LEN + 1);

  // (W + 1 - TAPS) mod DEPTH rewritten as W + (DEPTH - TAPS + 1) so the
  // arithmetic never goes negative; TAPS <= DEPTH keeps the constant >= 1.
  localparam logic [ADDR_W-1:0] RD_OFFSET = ADDR_W'((DEPTH - TAPS + 1) % DEPTH);
  localparam logic [CNT_W-1:0]  TAPS_C    = CNT_W'(TAPS);
  localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(TAPS - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(RUN_LEN - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  smpl_cnt_reg, smpl_cnt_next;
  logic [CNT_W-1:0]  tap_cnt_reg, tap_cnt_next;
  logic              filled_reg, filled_next;
  logic              overrun_reg, overrun_next;
  logic              rd_load, rd_inc;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  mod_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk      (clk),
    .clr      (rst),
    .load     (1'b0),
    .load_val ('0),
    .inc      (bus.smpl_vld),
    .ptr      (wr_ptr)
  );

  mod_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk      (clk),
    .clr      (rst),
    .load     (rd_load),
    .load_val (wr_ptr + RD_OFFSET),
    .inc      (rd_inc),
    .ptr      (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FILL;
      smpl_cnt_reg <= '0;
      tap_cnt_reg  <= '0;
      filled_reg   <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      smpl_cnt_reg <= smpl_cnt_next;
      tap_cnt_reg  <= tap_cnt_next;
      filled_reg   <= filled_next;
      overrun_reg  <= overrun_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    smpl_cnt_next = smpl_cnt_reg;
    tap_cnt_next  = tap_cnt_reg;
    filled_next   = filled_reg;
    overrun_next  = overrun_reg;
    rd_load       = 1'b0;
    rd_inc        = 1'b0;

    unique case (state_reg)
      FILL: begin
        if (bus.smpl_vld) begin
          if (smpl_cnt_reg != TAPS_C) begin
            smpl_cnt_next = smpl_cnt_reg + 1'b1;
          end
          // The pulse that brings the count to TAPS launches the first run;
          // wr_ptr still addresses the sample being written this cycle.
          if (smpl_cnt_reg == FILL_LAST) begin
            state_next   = RUN;
            filled_next  = 1'b1;
            rd_load      = 1'b1;
            tap_cnt_next = '0;
          end
        end
      end

      IDLE: begin
        if (bus.smpl_vld) begin
          state_next   = RUN;
          rd_load      = 1'b1;
          tap_cnt_next = '0;
        end
      end

      RUN: begin
        if (bus.smpl_vld) begin
          overrun_next = 1'b1;
        end
        // Address the TAPS samples, then hold while the pipeline drains.
        if (tap_cnt_reg < TAPS_C) begin
          rd_inc = 1'b1;
        end
        if (tap_cnt_reg == RUN_LAST) begin
          state_next = DONE;
        end else begin
          tap_cnt_next = tap_cnt_reg + 1'b1;
        end
      end

      DONE: begin
        // A sample here is written but does not start a run; DONE always
        // returns to IDLE so sequencing gets its low cycle.
        if (bus.smpl_vld) begin
          overrun_next = 1'b1;
        end
        state_next = IDLE;
      end

      default: state_next = FILL;
    endcase
  end

  assign bus.wr_en      = bus.smpl_vld;
  assign bus.wr_ptr     = wr_ptr;
  assign bus.rd_ptr     = rd_ptr;
  assign bus.sequencing = (state_reg == RUN);
  assign bus.filt_vld   = (state_reg == DONE);
  assign bus.filled     = filled_reg;
  assign bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_band_seq.sv
// tb_band_seq
//   Stimulus issues one cycle at a time and pushes the expected per-cycle
//   outputs (and, for each run launched, the expected starting read address)
//   from a timing-level model. A monitor on the falling edge pops and
//   compares. Pass/fail counts feed the summary line.
module tb_band_seq;
  import band_seq_pkg::*;

  localparam int DEPTH   = DEF_DEPTH;
  localparam int TAPS    = DEF_TAPS;
  localparam int LAT     = DEF_LAT;
  localparam int RUN_LEN = TAPS + LAT;

  typedef struct {
    bit vld;
    int wr_ptr;
    int rd_ptr;
    bit filled;
    bit overrun;
    bit seq;
    bit fv;
  } cyc_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  band_seq_if #(.DEPTH(DEPTH)) bus ();

  band_seq #(.DEPTH(DEPTH), .TAPS(TAPS), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  cyc_exp_t cyc_q[$];
  int       run_q[$];

  // Model state: time-stamped view of the last run rather than an FSM.
  int cyc      = 0;
  int npulse   = 0;
  bit filled_m = 0;
  bit overrun_m = 0;
  bit run_on   = 0;
  int rs       = 0;   // first cycle with sequencing high
  int rd0      = 0;   // read address at rs
  int rd_idle  = 0;   // read address before the current run started

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int rd_now(input int t);
    int k;
    if (run_on && t >= rs) begin
      k = t - rs;
      if (k > TAPS) k = TAPS;
      return (rd0 + k) % DEPTH;
    end
    return rd_idle;
  endfunction

  task automatic step(input bit vld, input bit r);
    cyc_exp_t e;
    int t;
    int w;
    bit busy;
    t = cyc;
    bus.smpl_vld = vld;
    rst = r;

    e.vld     = vld;
    e.wr_ptr  = npulse % DEPTH;
    e.rd_ptr  = rd_now(t);
    e.filled  = filled_m;
    e.overrun = overrun_m;
    e.seq     = run_on && t >= rs && t < rs + RUN_LEN;
    e.fv      = run_on && t == rs + RUN_LEN;
    cyc_q.push_back(e);

    if (r) begin
      npulse = 0; filled_m = 0; overrun_m = 0; run_on = 0; rd_idle = 0;
    end else if (vld) begin
      w    = npulse % DEPTH;
      busy = run_on && t <= rs + RUN_LEN;
      npulse++;
      if (!filled_m) begin
        if (npulse == TAPS) begin
          filled_m = 1;
          rd_idle = rd_now(t); rd0 = (w + 1 + DEPTH - TAPS) % DEPTH; rs = t + 1; run_on = 1;
          run_q.push_back(rd0);
        end
      end else if (busy) begin
        overrun_m = 1;
      end else begin
        rd_idle = rd_now(t); rd0 = (w + 1 + DEPTH - TAPS) % DEPTH; rs = t + 1; run_on = 1;
        run_q.push_back(rd0);
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Monitor
  initial begin
    cyc_exp_t e;
    bit seq_prev = 0;
    bit tracking = 0;
    int run_len  = 0;
    int exp_start;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("wr_en",      bus.wr_en,      e.vld);
        check("wr_ptr",     bus.wr_ptr,     e.wr_ptr);
        check("rd_ptr",     bus.rd_ptr,     e.rd_ptr);
        check("filled",     bus.filled,     e.filled);
        check("overrun",    bus.overrun,    e.overrun);
        check("sequencing", bus.sequencing, e.seq);
        check("filt_vld",   bus.filt_vld,   e.fv);
      end
      if (bus.sequencing === 1'b1 && !seq_prev) begin
        if (run_q.size() == 0) begin
          check("run_unexpected", 1, 0);
        end else begin
          exp_start = run_q.pop_front();
          check("run_start_rd", bus.rd_ptr, exp_start);
        end
        tracking = 1;
        run_len  = 0;
      end
      if (tracking) begin
        if (bus.sequencing === 1'b1) begin
          run_len++;
        end else begin
          check("run_len", run_len, RUN_LEN);
          check("run_done_filt_vld", bus.filt_vld, 1);
          tracking = 0;
        end
        if (rst) tracking = 0;
      end
      seq_prev = (bus.sequencing === 1'b1);
    end
  end

  // Stimulus
  initial begin
    bus.smpl_vld = 1'b0;
    @(posedge clk);
    #1;

    // Reset, with sample strobes to exercise wr_en during reset.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Fill: TAPS pulses four cycles apart; the last launches the first run.
    for (int i = 0; i < TAPS; i++) begin
      step(1'b1, 1'b0);
      idle(3);
    end
    idle(RUN_LEN + 4);

    // Steady state (write at 1021), then writes at 1022 and 1023 (wrap).
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      idle(RUN_LEN + 3);
    end
    // First write after the wrap lands at address 0.
    step(1'b1, 1'b0);
    idle(RUN_LEN + 3);

    // Overrun: a sample 100 cycles into a run.
    step(1'b1, 1'b0);
    idle(100);
    step(1'b1, 1'b0);
    idle(RUN_LEN + 5);

    // Randomized gaps and stray samples inside runs.
    for (int r = 0; r < 8; r++) begin
      idle($urandom_range(0, 20));
      step(1'b1, 1'b0);
      for (int k = 0; k < RUN_LEN + 2; k++) step($urandom_range(0, 199) == 0, 1'b0);
    end

    // Idle stability.
    idle(RUN_LEN + 5000);

    // Reset in the middle of a run, then partial refill from address 0.
    step(1'b1, 1'b0);
    idle(499);
    step(1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      idle(3);
    end
    idle(4);

    @(negedge clk);
    #1;
    check("cycle_queue_drained", cyc_q.size(), 0);
    check("runs_all_seen", run_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
